// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared register-index width, write-enable encodings and grant type
package wb_arbiter_pkg;
    localparam int REG_IDX_W = 3;
    localparam int NUM_REGS = 1 << REG_IDX_W;
    localparam logic REGWE_WRITE = 1'b1;
    localparam logic REGWE_IDLE = 1'b0;
    typedef enum logic [1:0] {GNT_NONE, GNT_ALU, GNT_LSU} gnt_e;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: LSU result queue, DEPTH entries of WIDTH bits, first-word-fall-through head
//   push_i/din_i write side, pop_i/dout_o read side (dout_o valid while count_o != 0)
//   count_o occupancy 0..DEPTH, full_o when count_o == DEPTH
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 19,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic push_ok, pop_ok;
    // a full queue still takes a push when the head leaves in the same cycle
    always_comb begin
        pop_ok = pop_i && (count_q != '0);
        push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);
        wr_ptr_d = push_ok ? ((wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? ((rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end
    assign dout_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o = (count_q == CW'(DEPTH));
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write-back arbiter between a single-cycle ALU and a queued LSU
//   alu_valid/alu_rd/alu_data: ALU result, no back-pressure except the registered alu_hold
//   lsu_valid/lsu_ready/lsu_rd/lsu_data: load results into the FIFO
//   iss_valid/iss_rd: destination issued, marks busy; rd/WB/RegWe: registered write port
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int CPU_WIDTH = 16,
    parameter int LSU_DEPTH = 2,
    parameter int AGE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [CPU_WIDTH-1:0] alu_data,
    input  logic                 lsu_valid,
    output logic                 lsu_ready,
    input  logic [REG_IDX_W-1:0] lsu_rd,
    input  logic [CPU_WIDTH-1:0] lsu_data,
    input  logic                 iss_valid,
    input  logic [REG_IDX_W-1:0] iss_rd,
    output logic                 alu_hold,
    output logic [REG_IDX_W-1:0] rd,
    output logic [CPU_WIDTH-1:0] WB,
    output logic                 RegWe,
    output logic [NUM_REGS-1:0]  busy
);
    localparam int EW = REG_IDX_W + CPU_WIDTH;
    localparam int CW = $clog2(LSU_DEPTH + 1);
    localparam int AGW = $clog2(AGE_MAX + 1);
    logic [EW-1:0] head;
    logic [CW-1:0] fifo_count;
    logic fifo_full, fifo_pop;
    gnt_e gnt;
    logic [REG_IDX_W-1:0] sel_rd, rd_q, rd_d;
    logic [CPU_WIDTH-1:0] sel_data, wb_q, wb_d;
    logic regwe_q, regwe_d, alu_hold_q, alu_hold_d;
    logic [AGW-1:0] age_q, age_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    wb_fifo #(.DEPTH(LSU_DEPTH), .WIDTH(EW)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push_i(lsu_valid && lsu_ready),
        .din_i({lsu_rd, lsu_data}),
        .pop_i(fifo_pop),
        .dout_o(head),
        .count_o(fifo_count),
        .full_o(fifo_full)
    );
    // ALU wins unless the FIFO head has aged out; alu_valid is ignored while holding
    always_comb begin
        gnt = (!alu_hold_q && alu_valid) ? GNT_ALU : (fifo_count != '0) ? GNT_LSU : GNT_NONE;
        fifo_pop = (gnt == GNT_LSU);
        sel_rd = (gnt == GNT_ALU) ? alu_rd : head[EW-1 -: REG_IDX_W];
        sel_data = (gnt == GNT_ALU) ? alu_data : head[CPU_WIDTH-1:0];
        rd_d = (gnt == GNT_NONE) ? rd_q : sel_rd;
        wb_d = (gnt == GNT_NONE) ? wb_q : sel_data;
        regwe_d = (gnt != GNT_NONE && sel_rd != '0) ? REGWE_WRITE : REGWE_IDLE;
        age_d = (fifo_pop || fifo_count == '0) ? '0 : (age_q == AGW'(AGE_MAX)) ? age_q : age_q + 1'b1;
        alu_hold_d = (age_d == AGW'(AGE_MAX));
    end
    // a retiring write clears its bit before a same-cycle issue sets it again
    always_comb begin
        busy_d = busy_q;
        if (regwe_q == REGWE_WRITE) busy_d[rd_q] = 1'b0;
        if (iss_valid) busy_d[iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
            wb_q <= '0;
            regwe_q <= REGWE_IDLE;
            alu_hold_q <= 1'b0;
            age_q <= '0;
            busy_q <= '0;
        end else begin
            rd_q <= rd_d;
            wb_q <= wb_d;
            regwe_q <= regwe_d;
            alu_hold_q <= alu_hold_d;
            age_q <= age_d;
            busy_q <= busy_d;
        end
    end
    assign lsu_ready = !fifo_full;
    assign alu_hold = alu_hold_q;
    assign rd = rd_q;
    assign WB = wb_q;
    assign RegWe = regwe_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed write-back arbiter checks with immediate assertions
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic alu_valid = 1'b0;
    logic [2:0] alu_rd = '0;
    logic [15:0] alu_data = '0;
    logic lsu_valid = 1'b0;
    logic lsu_ready;
    logic [2:0] lsu_rd = '0;
    logic [15:0] lsu_data = '0;
    logic iss_valid = 1'b0;
    logic [2:0] iss_rd = '0;
    logic alu_hold;
    logic [2:0] rd;
    logic [15:0] WB;
    logic RegWe;
    logic [7:0] busy;
    int checks = 0;
    int failures = 0;

    wb_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .alu_hold(alu_hold), .rd(rd), .WB(WB), .RegWe(RegWe), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic alu(input logic v, input logic [2:0] r, input logic [15:0] d);
        alu_valid = v;
        alu_rd = r;
        alu_data = d;
    endtask

    task automatic lsu(input logic v, input logic [2:0] r, input logic [15:0] d);
        lsu_valid = v;
        lsu_rd = r;
        lsu_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_regwe", RegWe, 0);
        chk("rst_rd", rd, 0);
        chk("rst_wb", WB, 0);
        chk("rst_busy", busy, 0);
        chk("rst_hold", alu_hold, 0);
        chk("rst_ready", lsu_ready, 1);

        alu(1, 3, 16'h1234);
        tick();
        chk("alu_regwe", RegWe, 1);
        chk("alu_rd", rd, 3);
        chk("alu_wb", WB, 16'h1234);
        alu(0, 0, 0);
        tick();
        chk("alu_once", RegWe, 0);

        chk("lsu_ready_pre", lsu_ready, 1);
        lsu(1, 5, 16'hBEEF);
        tick();
        chk("lsu_n1", RegWe, 0);
        lsu(0, 0, 0);
        tick();
        chk("lsu_n2_regwe", RegWe, 1);
        chk("lsu_n2_rd", rd, 5);
        chk("lsu_n2_wb", WB, 16'hBEEF);
        tick();
        chk("lsu_once", RegWe, 0);

        alu(1, 6, 16'h0600);
        lsu(1, 1, 16'hAAAA);
        tick();
        chk("age_alu0_rd", rd, 6);
        lsu(1, 2, 16'hBBBB);
        tick();
        chk("age_full", lsu_ready, 0);
        lsu(0, 0, 0);
        tick();
        chk("age_no_hold", alu_hold, 0);
        tick();
        chk("age_hold_a", alu_hold, 1);
        chk("age_alu3_rd", rd, 6);
        alu(1, 7, 16'h7777);
        tick();
        chk("age_a_regwe", RegWe, 1);
        chk("age_a_rd", rd, 1);
        chk("age_a_wb", WB, 16'hAAAA);
        chk("age_hold_drop", alu_hold, 0);
        chk("age_ready_back", lsu_ready, 1);
        alu(1, 6, 16'h0601);
        tick();
        chk("age_alu5_wb", WB, 16'h0601);
        tick();
        tick();
        chk("age_hold_b", alu_hold, 1);
        tick();
        chk("age_b_rd", rd, 2);
        chk("age_b_wb", WB, 16'hBBBB);
        chk("age_b_hold", alu_hold, 0);
        alu(0, 0, 0);
        tick();
        chk("age_drained", RegWe, 0);

        iss_valid = 1'b1;
        iss_rd = 4;
        tick();
        chk("busy_set", busy, 8'h10);
        iss_valid = 1'b0;
        alu(1, 4, 16'h4444);
        tick();
        chk("busy_wr_rd", rd, 4);
        alu(0, 0, 0);
        iss_valid = 1'b1;
        tick();
        chk("busy_set_wins", busy, 8'h10);
        iss_valid = 1'b0;
        alu(1, 4, 16'h4445);
        tick();
        alu(0, 0, 0);
        iss_valid = 1'b1;
        iss_rd = 0;
        tick();
        chk("busy_clear_r0", busy, 8'h00);
        iss_valid = 1'b0;

        alu(1, 0, 16'hFFFF);
        lsu(1, 0, 16'h1111);
        tick();
        chk("r0_alu", RegWe, 0);
        lsu(1, 0, 16'h2222);
        tick();
        chk("r0_full", lsu_ready, 0);
        chk("r0_alu2", RegWe, 0);
        alu(0, 0, 0);
        lsu(0, 0, 0);
        tick();
        chk("r0_pop1", RegWe, 0);
        chk("r0_ready", lsu_ready, 1);
        tick();
        chk("r0_pop2", RegWe, 0);
        lsu(1, 7, 16'h7070);
        tick();
        lsu(0, 0, 0);
        tick();
        chk("r0_after_rd", rd, 7);
        chk("r0_after_wb", WB, 16'h7070);
        tick();

        alu(1, 0, 16'h0);
        iss_valid = 1'b1;
        for (int i = 1; i < 8; i++) begin
            iss_rd = 3'(i);
            if (i >= 6) lsu(1, 3, 16'h3333);
            tick();
        end
        iss_valid = 1'b0;
        lsu(0, 0, 0);
        chk("pre_rst_busy", busy, 8'hFE);
        chk("pre_rst_full", lsu_ready, 0);
        rst = 1'b1;
        alu(1, 5, 16'h5555);
        lsu(1, 5, 16'h5555);
        tick();
        chk("mid_rst_regwe", RegWe, 0);
        chk("mid_rst_rd", rd, 0);
        chk("mid_rst_wb", WB, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_hold", alu_hold, 0);
        chk("mid_rst_ready", lsu_ready, 1);
        rst = 1'b0;
        alu(0, 0, 0);
        lsu(0, 0, 0);
        tick();
        chk("post_rst_regwe1", RegWe, 0);
        tick();
        chk("post_rst_regwe2", RegWe, 0);
        chk("post_rst_ready", lsu_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
